// File: rtl/vga_timing_pkg.sv
// Shared 640x480 timing constants, widths and monitor state encoding for the VGA capture path.
package vga_timing_pkg;

  localparam int H_TOTAL = 800;
  localparam int V_TOTAL = 521;
  localparam int H_BP    = 144;
  localparam int H_FP    = 784;
  localparam int V_BP    = 31;
  localparam int V_FP    = 511;

  localparam int XY_W  = 10;
  localparam int CNT_W = 11;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    MEASURE = 2'd1,
    LOCKED  = 2'd2
  } mon_state_e;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/vga_sync_counter.sv
// Sync falling-edge detector with a saturating position counter and length capture.
module vga_sync_counter
  import vga_timing_pkg::*;
(
  input  logic             clk,
  input  logic             clr,
  input  logic             pix_en,
  input  logic             sync_n,
  input  logic             adv,
  output logic             fall,
  output logic [CNT_W-1:0] count_nxt,
  output logic [CNT_W-1:0] count_q,
  output logic [CNT_W-1:0] len_q
);

  logic             prev_q;
  logic             prev_d;
  logic [CNT_W-1:0] count_d;
  logic [CNT_W-1:0] len_d;

  always_comb begin
    fall      = pix_en && prev_q && !sync_n;
    count_nxt = count_q;
    if (fall) begin
      count_nxt = '0;
    end else if (adv) begin
      count_nxt = sat_inc(count_q);
    end
    prev_d  = pix_en ? sync_n : prev_q;
    count_d = pix_en ? count_nxt : count_q;
    // saturate the captured length so a lost-sync run never wraps to 0
    len_d   = fall ? sat_inc(count_q) : len_q;
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      prev_q  <= 1'b1;
      count_q <= '0;
      len_q   <= '0;
    end else begin
      prev_q  <= prev_d;
      count_q <= count_d;
      len_q   <= len_d;
    end
  end

endmodule

// File: rtl/vga_capture_monitor.sv
// VGA sink: measures line/frame geometry, locks to the expected timing and emits active pixels.
// state   | meaning
// SEARCH  | waiting for a vsync fall to start measuring
// MEASURE | one frame being checked for line and frame length
// LOCKED  | timing matches, active pixels are emitted
module vga_capture_monitor
  import vga_timing_pkg::*;
#(
  parameter int H_TOTAL_CFG = H_TOTAL,
  parameter int V_TOTAL_CFG = V_TOTAL,
  parameter int H_BP_CFG    = H_BP,
  parameter int H_FP_CFG    = H_FP,
  parameter int V_BP_CFG    = V_BP,
  parameter int V_FP_CFG    = V_FP
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              pix_en,
  input  logic              hsync,
  input  logic              vsync,
  input  logic [2:0]        red,
  input  logic [2:0]        green,
  input  logic [1:0]        blue,
  output logic              pix_valid,
  output logic [XY_W-1:0]   pix_x,
  output logic [XY_W-1:0]   pix_y,
  output logic [7:0]        pix_rgb,
  output logic              frame_done,
  output logic              locked,
  output logic [CNT_W-1:0]  line_len,
  output logic [CNT_W-1:0]  frame_lines,
  output logic [7:0]        err_count
);

  localparam logic [CNT_W-1:0] H_LAST = 11'(H_TOTAL_CFG - 1);
  localparam logic [CNT_W-1:0] V_LAST = 11'(V_TOTAL_CFG - 1);
  localparam logic [CNT_W-1:0] H_BP_C = 11'(H_BP_CFG);
  localparam logic [CNT_W-1:0] H_FP_C = 11'(H_FP_CFG);
  localparam logic [CNT_W-1:0] V_BP_C = 11'(V_BP_CFG);
  localparam logic [CNT_W-1:0] V_FP_C = 11'(V_FP_CFG);

  logic             h_fall, v_fall;
  logic [CNT_W-1:0] hcount_q, hcount_nxt, vcount_q, vcount_nxt;

  vga_sync_counter u_hcnt (
    .clk       (clk),
    .clr       (clr),
    .pix_en    (pix_en),
    .sync_n    (hsync),
    .adv       (1'b1),
    .fall      (h_fall),
    .count_nxt (hcount_nxt),
    .count_q   (hcount_q),
    .len_q     (line_len)
  );

  // vertical counter advances on line starts; its own fall (vsync) takes priority
  vga_sync_counter u_vcnt (
    .clk       (clk),
    .clr       (clr),
    .pix_en    (pix_en),
    .sync_n    (vsync),
    .adv       (h_fall),
    .fall      (v_fall),
    .count_nxt (vcount_nxt),
    .count_q   (vcount_q),
    .len_q     (frame_lines)
  );

  mon_state_e      state_q, state_d;
  logic            line_ok_q, line_ok_d;
  logic            line_first_q, line_first_d;
  logic [7:0]      err_q, err_d;
  logic            pix_valid_q, pix_valid_d;
  logic [XY_W-1:0] pix_x_q, pix_x_d, pix_y_q, pix_y_d;
  logic [7:0]      pix_rgb_q, pix_rgb_d;
  logic            frame_done_q, frame_done_d;
  logic            locked_q, locked_d;

  logic h_bad, v_bad, h_lost, in_active, drop;

  assign h_bad     = h_fall && (hcount_q != H_LAST);
  assign v_bad     = v_fall && (vcount_q != V_LAST);
  assign h_lost    = (hcount_nxt == CNT_MAX);
  assign in_active = (hcount_nxt >= H_BP_C) && (hcount_nxt < H_FP_C) &&
                     (vcount_nxt >= V_BP_C) && (vcount_nxt < V_FP_C);

  always_comb begin
    state_d      = state_q;
    line_ok_d    = line_ok_q;
    line_first_d = line_first_q;
    err_d        = err_q;
    pix_valid_d  = 1'b0;
    pix_x_d      = pix_x_q;
    pix_y_d      = pix_y_q;
    pix_rgb_d    = pix_rgb_q;
    frame_done_d = 1'b0;
    drop         = 1'b0;
    if (pix_en) begin
      frame_done_d = v_fall;
      if (v_fall) begin
        line_ok_d    = 1'b0;
        line_first_d = 1'b1;
      end else if (h_fall) begin
        line_ok_d    = line_first_q ? 1'b1 : (line_ok_q && !h_bad);
        line_first_d = 1'b0;
      end
      unique case (state_q)
        SEARCH:  if (v_fall) state_d = MEASURE;
        MEASURE: if (v_fall && line_ok_q && !v_bad) state_d = LOCKED;
        LOCKED: begin
          if (h_bad || v_bad || h_lost) begin
            state_d = SEARCH;
            drop    = 1'b1;
            if (err_q != 8'hFF) err_d = err_q + 8'd1;
          end
        end
        default: state_d = SEARCH;
      endcase
      if ((state_q == LOCKED) && !drop && in_active) begin
        pix_valid_d = 1'b1;
        pix_x_d     = 10'(hcount_nxt - H_BP_C);
        pix_y_d     = 10'(vcount_nxt - V_BP_C);
        pix_rgb_d   = {red, green, blue};
      end
    end
    locked_d = (state_d == LOCKED);
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q      <= SEARCH;
      line_ok_q    <= 1'b0;
      line_first_q <= 1'b0;
      err_q        <= '0;
      pix_valid_q  <= 1'b0;
      pix_x_q      <= '0;
      pix_y_q      <= '0;
      pix_rgb_q    <= '0;
      frame_done_q <= 1'b0;
      locked_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      line_ok_q    <= line_ok_d;
      line_first_q <= line_first_d;
      err_q        <= err_d;
      pix_valid_q  <= pix_valid_d;
      pix_x_q      <= pix_x_d;
      pix_y_q      <= pix_y_d;
      pix_rgb_q    <= pix_rgb_d;
      frame_done_q <= frame_done_d;
      locked_q     <= locked_d;
    end
  end

  assign pix_valid  = pix_valid_q;
  assign pix_x      = pix_x_q;
  assign pix_y      = pix_y_q;
  assign pix_rgb    = pix_rgb_q;
  assign frame_done = frame_done_q;
  assign locked     = locked_q;
  assign err_count  = err_q;

endmodule
